alu_operand_stage: RTL and testbench

//  ID/EX pipeline stage feeding the 32-bit ALU. Latches a decoded instruction
//  (ALU op, register operands, immediate, shamt, dest) with valid/ready handshake.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/operand_fwd_mux.sv | 33 +++
 rtl/alu_operand_stage.sv | 151 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, widths, held-instruction payload and immediate extension.
package alu_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned SHAMT_W = 5;

   localparam logic [OP_W-1:0] ALU_AND = 4'd0;
   localparam logic [OP_W-1:0] ALU_OR  = 4'd1;
   localparam logic [OP_W-1:0] ALU_NOR = 4'd2;
   localparam logic [OP_W-1:0] ALU_ADD = 4'd3;
   localparam logic [OP_W-1:0] ALU_SUB = 4'd4;
   localparam logic [OP_W-1:0] ALU_SLL = 4'd5;
   localparam logic [OP_W-1:0] ALU_SRL = 4'd6;
   localparam logic [OP_W-1:0] ALU_LUI = 4'd7;

   // b already holds the extended immediate when alu_src is set
   typedef struct packed {
      logic [OP_W-1:0]    alu_op;
      logic [DATA_W-1:0]  a;
      logic [DATA_W-1:0]  b;
      logic               alu_src;
      logic [REG_AW-1:0]  rs_addr;
      logic [REG_AW-1:0]  rt_addr;
      logic [REG_AW-1:0]  rd_addr;
      logic [SHAMT_W-1:0] shamt;
      logic               reg_write;
   } op_payload_t;

   function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                 input logic zext);
      if (zext)
         return {{(DATA_W-IMM_W){1'b0}}, imm};
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand bypass select: EX/MEM over MEM/WB over held data; hit_c feeds the hazard stall.
module operand_fwd_mux #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] addr,
   input  logic [DATA_W-1:0] held_data,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic [DATA_W-1:0] data_c,
   output logic              hit_c
);

   logic exmem_hit;
   logic memwb_hit;

   // register 0 is hardwired and never a forwarding source
   always_comb begin
      exmem_hit = exmem_reg_write && (exmem_rd == addr) && (addr != '0);
      memwb_hit = memwb_reg_write && (memwb_rd == addr) && (addr != '0);
      hit_c     = exmem_hit || memwb_hit;
      data_c    = held_data;
      if (exmem_hit)
         data_c = exmem_result;
      else if (memwb_hit)
         data_c = memwb_result;
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: one-entry valid/ready register with bypass (ALU_FWD_EN) or hazard stall.
module alu_operand_stage
   import alu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    in_alu_op,
   input  logic [DATA_W-1:0]  in_rs_data,
   input  logic [DATA_W-1:0]  in_rt_data,
   input  logic [IMM_W-1:0]   in_imm,
   input  logic               in_zext,
   input  logic               in_alu_src,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [REG_AW-1:0]  in_rs_addr,
   input  logic [REG_AW-1:0]  in_rt_addr,
   input  logic [REG_AW-1:0]  in_rd_addr,
   input  logic               in_reg_write,
   input  logic               exmem_reg_write,
   input  logic [REG_AW-1:0]  exmem_rd,
   input  logic [DATA_W-1:0]  exmem_result,
   input  logic               memwb_reg_write,
   input  logic [REG_AW-1:0]  memwb_rd,
   input  logic [DATA_W-1:0]  memwb_result,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OP_W-1:0]    ALUOperation,
   output logic [DATA_W-1:0]  A,
   output logic [DATA_W-1:0]  B,
   output logic [SHAMT_W-1:0] shamt,
   output logic [REG_AW-1:0]  out_rd_addr,
   output logic               out_reg_write
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]        state_q;
   logic [0:0]        state_d;
   op_payload_t       pay_q;
   op_payload_t       pay_d;
   op_payload_t       pay_in;
   logic              hold;
   logic              load;
   logic              hit_a;
   logic              hit_b;
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_b;

   // immediate is extended once at capture so B needs no muxing on the hot path
   always_comb begin
      pay_in.alu_op    = in_alu_op;
      pay_in.a         = in_rs_data;
      pay_in.b         = in_alu_src ? ext_imm(in_imm, in_zext) : in_rt_data;
      pay_in.alu_src   = in_alu_src;
      pay_in.rs_addr   = in_rs_addr;
      pay_in.rt_addr   = in_rt_addr;
      pay_in.rd_addr   = in_rd_addr;
      pay_in.shamt     = in_shamt;
      pay_in.reg_write = in_reg_write;
   end

   operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
      .addr            (pay_q.rs_addr),
      .held_data       (pay_q.a),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .data_c          (fwd_a),
      .hit_c           (hit_a)
   );

   operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
      .addr            (pay_q.rt_addr),
      .held_data       (pay_q.b),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .data_c          (fwd_b),
      .hit_c           (hit_b)
   );

`ifdef ALU_FWD_EN
   logic unused_hit;
   assign unused_hit = hit_a | hit_b;
   assign hold       = 1'b0;
   assign A          = fwd_a;
   assign B          = pay_q.alu_src ? pay_q.b : fwd_b;
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_a, fwd_b};
   // rt only matters when B actually comes from the register file
   assign hold       = (state_q == FULL) && (hit_a || (hit_b && !pay_q.alu_src));
   assign A          = pay_q.a;
   assign B          = pay_q.b;
`endif

   assign out_valid = (state_q == FULL) && !hold;
   assign in_ready  = (state_q == EMPTY) || (out_ready && !hold);
   assign load      = in_valid && in_ready && !flush;

   // next-state and payload update; flush beats any same-cycle load
   always_comb begin
      state_d = state_q;
      pay_d   = pay_q;
      if (flush) begin
         state_d         = EMPTY;
         pay_d.reg_write = 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (load) begin
                  state_d = FULL;
                  pay_d   = pay_in;
               end
            end
            FULL: begin
               if (load)
                  pay_d = pay_in;
               else if (out_ready && !hold)
                  state_d = EMPTY;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         pay_q   <= '0;
      end else begin
         state_q <= state_d;
         pay_q   <= pay_d;
      end
   end

   assign ALUOperation  = pay_q.alu_op;
   assign shamt         = pay_q.shamt;
   assign out_rd_addr   = pay_q.rd_addr;
   assign out_reg_write = pay_q.reg_write;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed plus random bench for alu_operand_stage against an instruction-level model (ALU_FWD_EN aware).
module tb_alu_operand_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready;
   logic [3:0]  in_alu_op;
   logic [31:0] in_rs_data, in_rt_data;
   logic [15:0] in_imm;
   logic        in_zext, in_alu_src;
   logic [4:0]  in_shamt, in_rs_addr, in_rt_addr, in_rd_addr;
   logic        in_reg_write;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        out_valid, out_ready;
   logic [3:0]  ALUOperation;
   logic [31:0] A, B;
   logic [4:0]  shamt, out_rd_addr;
   logic        out_reg_write;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_op(in_alu_op), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .in_imm(in_imm), .in_zext(in_zext), .in_alu_src(in_alu_src), .in_shamt(in_shamt),
      .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
      .in_reg_write(in_reg_write),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .out_valid(out_valid), .out_ready(out_ready), .ALUOperation(ALUOperation),
      .A(A), .B(B), .shamt(shamt), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
   );

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] rs_d;
      logic [31:0] rt_d;
      logic [15:0] imm;
      logic        zext;
      logic        src;
      logic [4:0]  sh;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        rw;
   } inst_t;

   inst_t m;
   logic  mv;
   int    passed = 0;
   int    total  = 0;
   logic [3:0] ops [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic writes(input logic [4:0] a);
      return a != 5'd0 && ((exmem_reg_write && exmem_rd == a) || (memwb_reg_write && memwb_rd == a));
   endfunction

   function automatic logic [31:0] bypass(input logic [4:0] a, input logic [31:0] d);
      if (a != 5'd0 && exmem_reg_write && exmem_rd == a) return exmem_result;
      if (a != 5'd0 && memwb_reg_write && memwb_rd == a) return memwb_result;
      return d;
   endfunction

   function automatic logic stalled();
`ifdef ALU_FWD_EN
      return 1'b0;
`else
      return mv && (writes(m.rs) || (!m.src && writes(m.rt)));
`endif
   endfunction

   function automatic logic [31:0] exp_a();
`ifdef ALU_FWD_EN
      return bypass(m.rs, m.rs_d);
`else
      return m.rs_d;
`endif
   endfunction

   function automatic logic [31:0] exp_b();
      logic [31:0] ext;
      ext = m.zext ? {16'h0000, m.imm} : 32'(signed'(m.imm));
      if (m.src) return ext;
`ifdef ALU_FWD_EN
      return bypass(m.rt, m.rt_d);
`else
      return m.rt_d;
`endif
   endfunction

   function automatic logic model_ready();
      return !mv || (out_ready && !stalled());
   endfunction

   // after inputs settle: compare every observable against the model
   task automatic settle();
      logic ev;
      #1;
      ev = mv && !stalled();
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("in_ready", 32'(in_ready), 32'(model_ready()));
      if (ev) begin
         chk("op", 32'(ALUOperation), 32'(m.op));
         chk("A", A, exp_a());
         chk("B", B, exp_b());
         chk("shamt", 32'(shamt), 32'(m.sh));
         chk("rd", 32'(out_rd_addr), 32'(m.rd));
         chk("reg_write", 32'(out_reg_write), 32'(m.rw));
      end
   endtask

   task automatic advance();
      if (flush) begin
         mv = 1'b0;
         m.rw = 1'b0;
      end else if (in_valid && model_ready()) begin
         mv = 1'b1;
         m  = '{in_alu_op, in_rs_data, in_rt_data, in_imm, in_zext, in_alu_src,
                in_shamt, in_rs_addr, in_rt_addr, in_rd_addr, in_reg_write};
      end else if (mv && out_ready && !stalled()) begin
         mv = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic offer(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd, input logic [15:0] imm,
                        input logic zext, input logic src, input logic [4:0] rd);
      in_valid = 1'b1; in_alu_op = op; in_rs_addr = rs; in_rs_data = rsd;
      in_rt_addr = rt; in_rt_data = rtd; in_imm = imm; in_zext = zext;
      in_alu_src = src; in_shamt = 5'(rd + 5'd1); in_rd_addr = rd; in_reg_write = 1'b1;
   endtask

   task automatic wb(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                     input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
      exmem_reg_write = erw; exmem_rd = erd; exmem_result = eres;
      memwb_reg_write = mrw; memwb_rd = mrd; memwb_result = mres;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_op"}, 32'(ALUOperation), 32'd0);
      chk({tag, "_A"}, A, 32'd0);
      chk({tag, "_B"}, B, 32'd0);
      chk({tag, "_shamt"}, 32'(shamt), 32'd0);
      chk({tag, "_rd"}, 32'(out_rd_addr), 32'd0);
      chk({tag, "_rw"}, 32'(out_reg_write), 32'd0);
   endtask

   initial begin
      ops = '{ALU_AND, ALU_OR, ALU_NOR, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_LUI};
      reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
      offer(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 16'd0, 1'b0, 1'b0, 5'd0);
      in_valid = 1'b0; in_shamt = 5'd0; in_reg_write = 1'b0;
      wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      mv = 1'b0; m = '0;
      @(negedge clk); @(negedge clk);
      #1 check_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      // ADD rs=1(5) rt=2(7)
      out_ready = 1'b1;
      offer(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 16'd0, 1'b0, 1'b0, 5'd9);
      settle(); advance();
      in_valid = 1'b0;
      settle();
      chk("t1_A", A, 32'd5); chk("t1_B", B, 32'd7); chk("t1_op", 32'(ALUOperation), 32'd3);
      advance();

      // ADDI sign-extended then ORI zero-extended, back to back
      offer(ALU_ADD, 5'd1, 32'd1, 5'd2, 32'd2, 16'hFFFF, 1'b0, 1'b1, 5'd3);
      settle(); advance();
      offer(ALU_OR, 5'd1, 32'd1, 5'd2, 32'd2, 16'hFFFF, 1'b1, 1'b1, 5'd4);
      settle();
      chk("t2_addi_B", B, 32'hFFFF_FFFF);
      advance();
      in_valid = 1'b0;
      settle();
      chk("t2_ori_B", B, 32'h0000_FFFF);
      advance();

      // backpressure with a pending offer, then drain
      offer(ALU_SUB, 5'd5, 32'h11, 5'd6, 32'h22, 16'h0, 1'b0, 1'b0, 5'd7);
      settle(); advance();
      out_ready = 1'b0;
      offer(ALU_NOR, 5'd8, 32'h33, 5'd9, 32'h44, 16'h0, 1'b0, 1'b0, 5'd10);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t3_stall_ready", 32'(in_ready), 32'd0);
         chk("t3_stall_A", A, 32'h11);
         advance();
      end
      out_ready = 1'b1;
      settle(); advance();
      in_valid = 1'b0;
      settle();
      chk("t3_next_A", A, 32'h33);
      advance();
      settle(); advance();

      // forwarding / hazard on held rs=3
      offer(ALU_ADD, 5'd3, 32'h55, 5'd4, 32'h66, 16'h0, 1'b0, 1'b0, 5'd11);
      settle(); advance();
      in_valid = 1'b0; out_ready = 1'b0;
      wb(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
      settle();
`ifdef ALU_FWD_EN
      chk("t4_A_exmem", A, 32'hAA);
`else
      chk("t5_hold_valid", 32'(out_valid), 32'd0);
      chk("t5_hold_ready", 32'(in_ready), 32'd0);
`endif
      advance();
      wb(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
      settle(); advance();
      wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      settle();
      chk("t5_clear_valid", 32'(out_valid), 32'd1);
      advance();
      out_ready = 1'b1;
      settle(); advance();
      offer(ALU_ADD, 5'd0, 32'h1234, 5'd4, 32'h66, 16'h0, 1'b0, 1'b0, 5'd12);
      settle(); advance();
      in_valid = 1'b0; out_ready = 1'b0;
      wb(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
      settle();
      chk("t4_r0_A", A, 32'h1234);
      advance();
      out_ready = 1'b1; wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      settle(); advance();

      // flush overrides a same-cycle load
      offer(ALU_SLL, 5'd1, 32'h77, 5'd2, 32'h88, 16'h0, 1'b0, 1'b0, 5'd13);
      settle(); advance();
      offer(ALU_SRL, 5'd1, 32'h99, 5'd2, 32'hAB, 16'h0, 1'b0, 1'b0, 5'd14);
      flush = 1'b1;
      settle();
      chk("t6_flush_ready", 32'(in_ready), 32'd1);
      advance();
      flush = 1'b0; in_valid = 1'b0;
      settle();
      chk("t6_flush_valid", 32'(out_valid), 32'd0);
      chk("t6_flush_rw", 32'(out_reg_write), 32'd0);
      advance();

      // asynchronous reset while FULL
      offer(ALU_LUI, 5'd2, 32'hCC, 5'd3, 32'hDD, 16'h1234, 1'b1, 1'b1, 5'd15);
      settle(); advance();
      in_valid = 1'b0; out_ready = 1'b0;
      settle();
      reset = 1'b0;
      #1 check_zero("midreset");
      mv = 1'b0; m = '0;
      @(negedge clk);
      reset = 1'b1;
      settle(); advance();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         in_alu_op    = ops[$urandom_range(0, 7)];
         in_rs_data   = $urandom;
         in_rt_data   = $urandom;
         in_imm       = 16'($urandom);
         in_zext      = 1'($urandom);
         in_alu_src   = 1'($urandom);
         in_shamt     = 5'($urandom);
         in_rs_addr   = 5'($urandom_range(0, 3));
         in_rt_addr   = 5'($urandom_range(0, 3));
         in_rd_addr   = 5'($urandom);
         in_reg_write = 1'($urandom);
         out_ready    = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 15) == 0);
         wb(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), $urandom);
         settle(); advance();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
